// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX datapaths: occupancy count,
// almost-full/empty thresholds, overflow/underflow pulses, flush and optional FWFT read.
module uart_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AF_THRESH = 60,
    parameter int unsigned AE_THRESH = 4,
    parameter int unsigned FWFT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("uart_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("uart_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] dout_q;
    logic              rd_acc;
    logic              wr_acc;
    logic [CW-1:0]     count_nxt;

    // A full FIFO may still take a write when the same edge frees a slot.
    always_comb begin
        rd_acc    = rd_en && !empty;
        wr_acc    = wr_en && (!full || rd_acc);
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            dout_q       <= '0;
        end else begin
            // Flags track the next count so they move on the same edge as count.
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == CW'(DEPTH));
            almost_full  <= (count_nxt >= CW'(AF_THRESH));
            almost_empty <= (count_nxt <= CW'(AE_THRESH));
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (FWFT == 0) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
                overflow  <= wr_en && !wr_acc;
                underflow <= rd_en && !rd_acc;
            end
        end
    end

    // Storage is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_comb begin
        if (FWFT != 0) begin
            data_out = empty ? '0 : mem[rd_ptr];
        end else begin
            data_out = dout_q;
        end
    end

endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench for uart_fifo_param: one standard and one FWFT instance share
// stimulus; expected status/data per cycle is queued and checked by a monitor.
module tb_uart_fifo_param;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] s_data, f_data;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [6:0] s_count, f_count;

    uart_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_THRESH(60), .AE_THRESH(4), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_data), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf));

    uart_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_THRESH(60), .AE_THRESH(4), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_data), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [12:0] st;
        logic [7:0]  sdata;
        logic        fchk;
        logic [7:0]  fdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mq[$];
    logic [7:0]  mdout = 8'h00;
    int unsigned cyc_n = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Status layout: {count, full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [12:0] pack(input int cnt, input logic ov, input logic un);
        return {7'(cnt), cnt == DEPTH, cnt == 0, cnt >= 60, cnt <= 4, ov, un};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc_n) begin
                    check("stale_entry", e.cyc, cyc_n);
                end else begin
                    check("std_status", {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, e.st);
                    check("std_data", s_data, e.sdata);
                    check("fwft_status", {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf}, e.st);
                    if (e.fchk) check("fwft_data", f_data, e.fdata);
                end
            end
        end
    end

    task automatic step(input logic wr, input logic rd, input logic [7:0] din, input logic fl);
        exp_t e;
        logic ra, wa, ov, un;
        @(negedge clk);
        wr_en = wr; rd_en = rd; data_in = din; flush = fl;
        ov = 1'b0; un = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            ra = rd && (mq.size() > 0);
            wa = wr && (mq.size() < DEPTH || ra);
            if (ra) mdout = mq.pop_front();
            if (wa) mq.push_back(din);
            ov = wr && !wa;
            un = rd && !ra;
        end
        e.cyc   = cyc_n + 1;
        e.st    = pack(mq.size(), ov, un);
        e.sdata = mdout;
        e.fchk  = (mq.size() > 0);
        e.fdata = e.fchk ? mq[0] : 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_std_status"}, {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, pack(0, 1'b0, 1'b0));
        check({tag, "_std_data"}, s_data, 8'h00);
        check({tag, "_fwft_status"}, {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf}, pack(0, 1'b0, 1'b0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;

        for (int i = 1; i <= 64; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h41, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_check("midreset");
        mq.delete();
        mdout = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
